// File: rtl/wb_spi_bridge_if.sv
// -----------------------------------------------------------------------------
// wb_spi_bridge_if
// Wishbone classic slave-side bus bundle for the SPI bridge.
//   wb_cyc_i  : bus cycle in progress (master -> slave)
//   wb_stb_i  : strobe, access requested (master -> slave)
//   wb_we_i   : 1 = write, 0 = read (master -> slave)
//   wb_adr_i  : word address 0 CTRL, 1 TXDATA, 2 RXDATA, 3 STATUS
//   wb_dat_i  : write data (master -> slave)
//   wb_dat_o  : read data (slave -> master)
//   wb_ack_o  : normal termination (slave -> master)
//   wb_err_o  : error termination on engine timeout (slave -> master)
// -----------------------------------------------------------------------------
interface wb_spi_bridge_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [1:0]  wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_spi_bridge.sv
// -----------------------------------------------------------------------------
// wb_spi_bridge
// Bridges Wishbone classic register accesses onto a strobe/ack SPI engine.
// CTRL writes, TXDATA writes and RXDATA reads are forwarded to the engine and
// terminated when the engine acknowledges (or with wb_err_o after TIMEOUT+1
// cycles of silence). Every other access is answered locally.
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset
//   bus   : Wishbone slave bundle (wb_spi_bridge_if.slave)
//   din   : 11-bit data/settings to the engine
//   cmd   : settings-write strobe
//   wr    : TX-FIFO write strobe
//   rd    : RX-FIFO read strobe
//   dout  : engine read data, bit8 = RX empty, valid while rd = 1
//   ack   : engine acknowledge, one cycle after an accepted strobe
// -----------------------------------------------------------------------------
module wb_spi_bridge #(
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_spi_bridge_if.slave     bus,
    output logic [10:0]        din,
    output logic               cmd,
    output logic               wr,
    output logic               rd,
    input  logic [8:0]         dout,
    input  logic               ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_ACK,
        S_RESP,
        S_ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];

    state_t      r_state,  w_state;
    logic [1:0]  r_adr,    w_adr;
    logic        r_we,     w_we;
    logic        r_abort,  w_abort;
    logic [7:0]  r_cnt,    w_cnt;
    logic [10:0] r_shadow, w_shadow;
    logic        r_flag,   w_flag;
    logic [8:0]  r_rxData, w_rxData;
    logic [10:0] r_din,    w_din;
    logic        r_cmd,    w_cmd;
    logic        r_wr,     w_wr;
    logic        r_rd,     w_rd;
    logic        r_wbAck,  w_wbAck;
    logic        r_wbErr,  w_wbErr;
    logic [31:0] r_wbDat,  w_wbDat;

    logic        w_isCtrlWr;
    logic        w_isTxWr;
    logic        w_isRxRd;
    logic        w_abortNow;
    logic        w_unused;

    // Only the low 11 data bits reach the engine; the rest are ignored.
    assign w_unused = &{1'b0, bus.wb_dat_i[31:11]};

    // Decode of the three access types that need the engine.
    assign w_isCtrlWr = bus.wb_we_i  && (bus.wb_adr_i == 2'd0);
    assign w_isTxWr   = bus.wb_we_i  && (bus.wb_adr_i == 2'd1);
    assign w_isRxRd   = !bus.wb_we_i && (bus.wb_adr_i == 2'd2);

    // A master that lets go of cyc while we wait on the engine gets no
    // termination; the engine handshake is still finished cleanly.
    assign w_abortNow = r_abort || !bus.wb_cyc_i;

    // Next-state and next-output logic. Every output is computed here one
    // cycle early and registered below, so strobes and terminations are
    // glitch-free and last exactly one cycle unless the FSM says otherwise.
    always_comb begin
        w_state  = r_state;
        w_adr    = r_adr;
        w_we     = r_we;
        w_abort  = r_abort;
        w_cnt    = r_cnt;
        w_shadow = r_shadow;
        w_flag   = r_flag;
        w_rxData = r_rxData;
        w_din    = r_din;
        w_cmd    = 1'b0;
        w_wr     = 1'b0;
        w_rd     = 1'b0;
        w_wbAck  = 1'b0;
        w_wbErr  = 1'b0;
        w_wbDat  = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (bus.wb_cyc_i && bus.wb_stb_i) begin
                    w_adr   = bus.wb_adr_i;
                    w_we    = bus.wb_we_i;
                    w_abort = 1'b0;
                    if (w_isCtrlWr || w_isTxWr || w_isRxRd) begin
                        w_state = S_REQ;
                        w_din   = bus.wb_dat_i[10:0];
                        w_cmd   = w_isCtrlWr;
                        w_wr    = w_isTxWr;
                        w_rd    = w_isRxRd;
                    end else begin
                        w_state = S_RESP;
                        w_wbAck = 1'b1;
                        if (!bus.wb_we_i) begin
                            case (bus.wb_adr_i)
                                2'd0:    w_wbDat = {21'd0, r_shadow};
                                2'd3:    w_wbDat = {r_flag, 20'd0, r_shadow};
                                default: w_wbDat = 32'd0;
                            endcase
                        end
                    end
                end
            end

            S_REQ: begin
                // dout is only valid while rd is high, so grab it now.
                if (r_rd) begin
                    w_rxData = dout;
                end
                w_abort = w_abortNow;
                w_cnt   = 8'd0;
                w_state = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                w_abort = w_abortNow;
                if (ack) begin
                    w_state = S_RESP;
                    w_wbAck = !w_abortNow;
                    if (r_we && (r_adr == 2'd0)) begin
                        w_shadow = r_din;
                    end
                    if (!r_we && !w_abortNow) begin
                        w_wbDat = {23'd0, r_rxData};
                    end
                end else if (r_cnt == TIMEOUT_CNT) begin
                    w_state = S_ERR;
                    w_wbErr = !w_abortNow;
                    if (!w_abortNow) begin
                        w_flag = 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 8'd1;
                end
            end

            S_RESP: begin
                // Reading STATUS consumes the sticky timeout flag.
                if (!r_we && (r_adr == 2'd3) && !r_abort) begin
                    w_flag = 1'b0;
                end
                w_state = S_IDLE;
            end

            S_ERR: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_adr    <= 2'd0;
            r_we     <= 1'b0;
            r_abort  <= 1'b0;
            r_cnt    <= 8'd0;
            r_shadow <= 11'd0;
            r_flag   <= 1'b0;
            r_rxData <= 9'd0;
            r_din    <= 11'd0;
            r_cmd    <= 1'b0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_wbAck  <= 1'b0;
            r_wbErr  <= 1'b0;
            r_wbDat  <= 32'd0;
        end else begin
            r_state  <= w_state;
            r_adr    <= w_adr;
            r_we     <= w_we;
            r_abort  <= w_abort;
            r_cnt    <= w_cnt;
            r_shadow <= w_shadow;
            r_flag   <= w_flag;
            r_rxData <= w_rxData;
            r_din    <= w_din;
            r_cmd    <= w_cmd;
            r_wr     <= w_wr;
            r_rd     <= w_rd;
            r_wbAck  <= w_wbAck;
            r_wbErr  <= w_wbErr;
            r_wbDat  <= w_wbDat;
        end
    end

    assign din          = r_din;
    assign cmd          = r_cmd;
    assign wr           = r_wr;
    assign rd           = r_rd;
    assign bus.wb_ack_o = r_wbAck;
    assign bus.wb_err_o = r_wbErr;
    assign bus.wb_dat_o = r_wbDat;

endmodule

// File: tb/tb_wb_spi_bridge.sv
// -----------------------------------------------------------------------------
// tb_wb_spi_bridge
// Directed self-checking bench for wb_spi_bridge (TIMEOUT = 15). A tiny
// engine model acks one cycle after any strobe when autoAck is set; manualAck
// lets a test place the engine ack on an exact cycle.
// -----------------------------------------------------------------------------
module tb_wb_spi_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] din;
    logic        cmd;
    logic        wr;
    logic        rd;
    logic [8:0]  dout;
    logic        ack;

    logic        autoAck = 1'b1;
    logic        manualAck = 1'b0;
    logic        ackAuto;
    logic [8:0]  doutVal = 9'd0;

    int checks = 0;
    int passes = 0;

    wb_spi_bridge_if bus();

    wb_spi_bridge #(.TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .din   (din),
        .cmd   (cmd),
        .wr    (wr),
        .rd    (rd),
        .dout  (dout),
        .ack   (ack)
    );

    always #5 clk = ~clk;

    // Engine model: registered ack one cycle after any accepted strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ackAuto <= 1'b0;
        else        ackAuto <= autoAck && (cmd || wr || rd);
    end
    assign ack  = ackAuto || manualAck;
    assign dout = doutVal;

    // One Wishbone access; returns what was observed, the number of edges
    // from the first sampling edge to the termination (stays 0 when the
    // access is never terminated), the strobes seen, and whether the bus is
    // quiet the cycle after.
    task automatic wbAccess(input logic we, input logic [1:0] adr, input logic [31:0] data,
                            output logic gotAck, output logic gotErr, output logic [31:0] rdata,
                            output int lat, output int nCmd, output int nWr, output int nRd,
                            output logic [10:0] sDin, output logic postIdle);
        gotAck = 0; gotErr = 0; rdata = 0; lat = 0; nCmd = 0; nWr = 0; nRd = 0; sDin = 0;
        @(negedge clk);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = we; bus.wb_adr_i = adr; bus.wb_dat_i = data;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (cmd) begin nCmd++; sDin = din; end
            if (wr)  begin nWr++;  sDin = din; end
            if (rd)  begin nRd++;  sDin = din; end
            if (bus.wb_ack_o || bus.wb_err_o) begin
                gotAck = bus.wb_ack_o; gotErr = bus.wb_err_o; rdata = bus.wb_dat_o; lat = i;
                break;
            end
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
        @(posedge clk);
        @(negedge clk);
        postIdle = !bus.wb_ack_o && !bus.wb_err_o && (bus.wb_dat_o == 32'd0);
    endtask

    task automatic test_reset();
        logic a, e, p; logic [31:0] d; int l, nc, nw, nr; logic [10:0] sd;
        #1;
        checks++; if ({cmd, wr, rd, din} !== 14'd0) $display("[TB] FAIL reset_strobes got=%h want=0", {cmd, wr, rd, din}); else passes++;
        checks++; if ({bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o} !== 34'd0) $display("[TB] FAIL reset_wb got=%h want=0", {bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o}); else passes++;
        @(negedge clk); rst_n = 1;
        wbAccess(0, 2'd3, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h0000_0000 || a !== 1) $display("[TB] FAIL reset_status got=%h ack=%b want=00000000 ack=1", d, a); else passes++;
    endtask

    task automatic test_ctrl_write();
        logic a, e, p; logic [31:0] d; int l, nc, nw, nr; logic [10:0] sd;
        wbAccess(1, 2'd0, 32'h0000_0405, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (l !== 3 || a !== 1 || e !== 0) $display("[TB] FAIL ctrl_wr_lat got lat=%0d ack=%b err=%b want lat=3 ack=1 err=0", l, a, e); else passes++;
        checks++; if (nc !== 1 || nw !== 0 || nr !== 0 || sd !== 11'h405) $display("[TB] FAIL ctrl_wr_strobe got cmd=%0d wr=%0d rd=%0d din=%h want 1/0/0 405", nc, nw, nr, sd); else passes++;
        checks++; if (p !== 1) $display("[TB] FAIL ctrl_wr_onecycle got idle=%b want 1", p); else passes++;
        wbAccess(0, 2'd0, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h0000_0405 || l !== 1) $display("[TB] FAIL ctrl_rd got=%h lat=%0d want=00000405 lat=1", d, l); else passes++;
        checks++; if (nc + nw + nr !== 0 || p !== 1) $display("[TB] FAIL ctrl_rd_local got strobes=%0d idle=%b want 0 1", nc + nw + nr, p); else passes++;
    endtask

    task automatic test_tx_write();
        logic a, e, p; logic [31:0] d; int l, nc, nw, nr; logic [10:0] sd;
        wbAccess(1, 2'd1, 32'h0000_01A5, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (l !== 3 || a !== 1 || e !== 0) $display("[TB] FAIL tx_wr_lat got lat=%0d ack=%b err=%b want lat=3 ack=1 err=0", l, a, e); else passes++;
        checks++; if (nw !== 1 || nc !== 0 || nr !== 0 || sd !== 11'h1A5) $display("[TB] FAIL tx_wr_strobe got cmd=%0d wr=%0d rd=%0d din=%h want 0/1/0 1a5", nc, nw, nr, sd); else passes++;
    endtask

    task automatic test_rx_read();
        logic a, e, p; logic [31:0] d; int l, nc, nw, nr; logic [10:0] sd;
        doutVal = 9'h03C;
        wbAccess(0, 2'd2, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h0000_003C || l !== 3 || nr !== 1) $display("[TB] FAIL rx_rd got=%h lat=%0d rd=%0d want=0000003c lat=3 rd=1", d, l, nr); else passes++;
        checks++; if (p !== 1) $display("[TB] FAIL rx_rd_dat_clear got idle=%b want 1", p); else passes++;
        doutVal = 9'h100;
        wbAccess(0, 2'd2, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h0000_0100) $display("[TB] FAIL rx_rd_empty got=%h want=00000100", d); else passes++;
        doutVal = 9'h0AA;
    endtask

    task automatic test_local();
        logic a, e, p; logic [31:0] d; int l, nc, nw, nr; logic [10:0] sd;
        wbAccess(0, 2'd1, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'd0 || l !== 1 || nc + nw + nr !== 0) $display("[TB] FAIL tx_rd got=%h lat=%0d strobes=%0d want=0 lat=1 0", d, l, nc + nw + nr); else passes++;
        wbAccess(1, 2'd2, 32'h0000_07FF, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (a !== 1 || l !== 1 || nc + nw + nr !== 0) $display("[TB] FAIL rx_wr got ack=%b lat=%0d strobes=%0d want 1 1 0", a, l, nc + nw + nr); else passes++;
        wbAccess(1, 2'd3, 32'hFFFF_FFFF, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (a !== 1 || l !== 1 || nc + nw + nr !== 0) $display("[TB] FAIL status_wr got ack=%b lat=%0d strobes=%0d want 1 1 0", a, l, nc + nw + nr); else passes++;
        wbAccess(0, 2'd3, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h0000_0405) $display("[TB] FAIL status_after_local got=%h want=00000405", d); else passes++;
    endtask

    task automatic test_timeout();
        logic a, e, p; logic [31:0] d; int l, nc, nw, nr; logic [10:0] sd;
        autoAck = 0;
        wbAccess(1, 2'd1, 32'h0000_0055, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (l !== 18 || e !== 1 || a !== 0) $display("[TB] FAIL tx_timeout got lat=%0d err=%b ack=%b want lat=18 err=1 ack=0", l, e, a); else passes++;
        checks++; if (p !== 1) $display("[TB] FAIL err_onecycle got idle=%b want 1", p); else passes++;
        wbAccess(1, 2'd0, 32'h0000_07FF, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (e !== 1 || l !== 18) $display("[TB] FAIL ctrl_timeout got err=%b lat=%0d want err=1 lat=18", e, l); else passes++;
        autoAck = 1;
        wbAccess(0, 2'd0, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h0000_0405) $display("[TB] FAIL shadow_no_update got=%h want=00000405", d); else passes++;
        wbAccess(0, 2'd3, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h8000_0405) $display("[TB] FAIL status_flag_set got=%h want=80000405", d); else passes++;
        wbAccess(0, 2'd3, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h0000_0405) $display("[TB] FAIL status_flag_clear got=%h want=00000405", d); else passes++;
    endtask

    task automatic test_ack_at_timeout();
        int early = 0;
        logic gotA = 0, gotE = 0;
        autoAck = 0;
        @(negedge clk);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_adr_i = 2'd1; bus.wb_dat_i = 32'h0000_0033;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c < 18 && (bus.wb_ack_o || bus.wb_err_o)) early++;
            if (c == 17) manualAck = 1;
            if (c == 18) begin
                manualAck = 0;
                gotA = bus.wb_ack_o;
                gotE = bus.wb_err_o;
            end
        end
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
        checks++; if (gotA !== 1 || gotE !== 0 || early !== 0) $display("[TB] FAIL ack_at_timeout got ack=%b err=%b early=%0d want 1 0 0", gotA, gotE, early); else passes++;
        repeat (2) @(negedge clk);
        autoAck = 1;
    endtask

    task automatic test_cyc_drop();
        logic a, e, p; logic [31:0] d; int l, nc, nw, nr; logic [10:0] sd;
        int seen = 0;
        autoAck = 0;
        @(negedge clk);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_adr_i = 2'd1; bus.wb_dat_i = 32'h0000_0011;
        repeat (4) @(negedge clk);
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (bus.wb_ack_o || bus.wb_err_o) seen++;
        end
        checks++; if (seen !== 0) $display("[TB] FAIL cyc_drop_term got=%0d want=0", seen); else passes++;
        autoAck = 1;
        wbAccess(0, 2'd3, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'h0000_0405) $display("[TB] FAIL cyc_drop_flag got=%h want=00000405", d); else passes++;
    endtask

    task automatic test_reset_mid();
        logic a, e, p; logic [31:0] d; int l, nc, nw, nr; logic [10:0] sd;
        int seen = 0;
        autoAck = 0;
        @(negedge clk);
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1; bus.wb_adr_i = 2'd1; bus.wb_dat_i = 32'h0000_01A5;
        repeat (5) @(negedge clk);
        rst_n = 0;
        #1;
        checks++; if ({cmd, wr, rd, din, bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o} !== 48'd0) $display("[TB] FAIL reset_mid_outputs got din=%h wr=%b want all 0", din, wr); else passes++;
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.wb_ack_o || bus.wb_err_o) seen++;
        end
        checks++; if (seen !== 0) $display("[TB] FAIL reset_mid_term got=%0d want=0", seen); else passes++;
        autoAck = 1;
        wbAccess(0, 2'd0, 0, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (d !== 32'd0) $display("[TB] FAIL reset_mid_shadow got=%h want=00000000", d); else passes++;
        wbAccess(1, 2'd0, 32'h0000_0123, a, e, d, l, nc, nw, nr, sd, p);
        checks++; if (l !== 3 || a !== 1 || sd !== 11'h123) $display("[TB] FAIL reset_mid_restart got lat=%0d ack=%b din=%h want 3 1 123", l, a, sd); else passes++;
    endtask

    initial begin
        bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0; bus.wb_adr_i = 0; bus.wb_dat_i = 0;
        test_reset();
        test_ctrl_write();
        test_tx_write();
        test_rx_read();
        test_local();
        test_timeout();
        test_ack_at_timeout();
        test_cyc_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/wb_spi_bridge.md
WB_SPI_BRIDGE -- requirements
Module: wb_spi_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, giving max cycles to wait in WAIT_ACK for ack (range 1..255).
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge system clock; rst input 1, async active-low reset.
REQ-003 wb_cyc_i  input  1  Wishbone classic cycle.
REQ-004 wb_stb_i  input  1  strobe.
REQ-005 wb_we_i  input  1  1=write.
REQ-006 wb_adr_i  input  2  word address: 0 CTRL, 1 TXDATA, 2 RXDATA, 3 STATUS.
REQ-007 wb_dat_i  input  32  write data.
REQ-008 wb_dat_o  output  32  read data.
REQ-009 wb_ack_o  output  1  normal termination.
REQ-010 wb_err_o  output  1  error termination (timeout).
REQ-011 din  output  11  data/settings to SPI engine.
REQ-012 cmd  output  1  settings-write strobe.
REQ-013 wr  output  1  TX-FIFO write strobe.
REQ-014 rd  output  1  RX-FIFO read strobe.
REQ-015 dout  input  9  read data from engine; bit8=1 means RX empty; valid only in the cycle rd=1.
REQ-016 ack  input  1  engine acknowledge, one cycle after an accepted cmd/wr/rd.

Function
REQ-017 SHALL implement FSM IDLE, REQ, WAIT_ACK, RESP, ERR; all outputs registered.
REQ-018 IDLE: on cyc&stb, write to CTRL, TXDATA or read of RXDATA -> REQ; any other access -> RESP (local).
REQ-019 REQ (exactly 1 cycle): drive exactly one strobe (cmd for CTRL write, wr for TXDATA write, rd for RXDATA read) with din=wb_dat_i[10:0]; -> WAIT_ACK.
REQ-020 In the REQ cycle for RXDATA, SHALL capture dout[8:0] into a read-data register.
REQ-021 WAIT_ACK: timeout counter cleared on entry, +1 per cycle; ack=1 -> RESP; counter==TIMEOUT with ack=0 -> ERR; ack wins if both in the same cycle.
REQ-022 RESP: wb_ack_o=1 for exactly 1 cycle; -> IDLE. ERR: wb_err_o=1 for exactly 1 cycle, sets sticky timeout flag; -> IDLE.
REQ-023 Latency for engine access: stb sampled at edge n, strobe high n+1, ack at n+2, wb_ack_o at n+3. Local access: wb_ack_o at n+1.
REQ-024 CTRL write SHALL also update 11-bit shadow register with wb_dat_i[10:0] when the engine acks (not on timeout).
REQ-025 Reads: CTRL and STATUS return {21'b0, shadow}, except STATUS bit31 = sticky timeout flag; RXDATA returns {23'b0, captured dout}; TXDATA reads return 0.
REQ-026 STATUS read SHALL clear the sticky timeout flag in its RESP cycle; a set from ERR in the same cycle cannot occur (FSM serial).
REQ-027 Writes to RXDATA/STATUS and reads of TXDATA SHALL be acked locally and have no side effect.
REQ-028 If cyc drops during WAIT_ACK, FSM SHALL keep waiting for ack/timeout but suppress wb_ack_o/wb_err_o and the sticky flag update.
REQ-029 wb_dat_o SHALL be 0 except in a RESP cycle of a read.
REQ-030 Write to TXDATA while engine FIFO full yields no ack -> ERR after TIMEOUT+1 WAIT_ACK cycles.

Reset
REQ-031 rst low SHALL asynchronously force IDLE and cmd=wr=rd=0, din=0, wb_ack_o=wb_err_o=0, wb_dat_o=0, shadow=0, flag=0, counter=0.
REQ-032 rst asserted mid-transaction SHALL abort it with no termination; first access after release starts from IDLE.

Verification
REQ-033 Write CTRL 0x0000_0405 -> cmd=1 with din=0x405 one cycle; ack from engine -> wb_ack_o at n+3; CTRL read returns 0x0000_0405.
REQ-034 Write TXDATA 0x1A5, engine acks -> wr=1 with din=0x1A5, wb_ack_o at n+3, wb_err_o never 1.
REQ-035 Read RXDATA with engine dout=0x03C during rd -> wb_dat_o=0x0000_003C on ack; empty case dout=0x100 -> 0x0000_0100.
REQ-036 Write TXDATA, engine never acks, TIMEOUT=15 -> wb_err_o 1 cycle after 16 WAIT_ACK cycles; STATUS read bit31=1, next STATUS read bit31=0.
REQ-037 Ack on same cycle counter reaches TIMEOUT -> wb_ack_o, no wb_err_o; rst pulse in WAIT_ACK -> all outputs 0 immediately, no termination.
